utrap_seq: RTL and testbench

Microtrap sequencer sitting directly downstream of the ACV/alignment checker. It arbitrates the checker's encoded microtrap and access-violation outputs, and stalls the microcycle for a fixed flush window. It then presents a trap vector offset to the microsequencer under an accept handshake and drives `utrap_l` back to the checker. It also registers the probe micro-vector and flags traps that arrive while one is already in progress.

---
 rtl/utrap_seq.sv | 196 +++++++++++++++++++
 tb/tb_utrap_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/utrap_seq.sv
// utrap_seq: microtrap sequencer behind the ACV/alignment checker.
// Arbitrates the encoded microtrap and ACV terms, stalls the microcycle for a
// flush window, presents a trap vector offset until the sequencer acknowledges,
// then masks new requests for a short window. Also captures the probe vector
// and flags traps that arrive while one is already in progress.
module utrap_seq #(
    parameter int unsigned STALL_CYC = 2,
    parameter int unsigned MASK_CYC  = 1
) (
    input  logic       b_clk_l,
    input  logic       init_l,
    input  logic       m_clk_en_h,
    input  logic [2:0] enc_utrap_l,
    input  logic       acv_h,
    input  logic       acv_chk_en_h,
    input  logic       pte_check_or_probe_h,
    input  logic [1:0] micro_vector_h,
    input  logic       trap_dis_h,
    input  logic       trap_ack_h,
    input  logic       clr_dbl_h,
    output logic       utrap_l,
    output logic [3:0] trap_addr_h,
    output logic       clk_stall_h,
    output logic       trap_busy_h,
    output logic       double_trap_h,
    output logic [1:0] uvec_h
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_MASK  = 2'd3
    } state_t;

    // Counter reload values; the counter holds "edges remaining minus one".
    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 32'd1);
    localparam logic [3:0] MASK_LOAD  = (MASK_CYC == 32'd0) ? 4'h0 : 4'(MASK_CYC - 32'd1);
    localparam bit         MASK_EN    = (MASK_CYC != 32'd0);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_addr;
    logic       r_dbl;
    logic [1:0] r_uvec;
    logic       r_utrap_l;
    logic       r_stall;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_addr_nxt;
    logic       w_dbl_nxt;
    logic [1:0] w_uvec_nxt;

    logic [2:0] w_code;
    logic       w_acv_term;
    logic       w_treq;
    logic [3:0] w_rc;
    logic       w_in_trap;
    logic       w_nest;
    logic       w_nest_par;

    // Request decode: encoded microtrap has precedence over the ACV term.
    always_comb begin
        w_code     = ~enc_utrap_l;
        w_acv_term = acv_h & acv_chk_en_h & ~pte_check_or_probe_h;
        w_treq     = (w_code != 3'd0) | w_acv_term;
        if (w_code != 3'd0) begin
            w_rc = {1'b0, w_code};
        end else if (w_acv_term) begin
            w_rc = 4'h8;
        end else begin
            w_rc = 4'h0;
        end
        w_in_trap  = (r_state == ST_FLUSH) || (r_state == ST_ISSUE);
        w_nest     = w_in_trap & m_clk_en_h & w_treq;
        w_nest_par = w_nest & (w_code == 3'd7);
    end

    // Next-state, counter and trap-address logic for the trap FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (m_clk_en_h && w_treq && !trap_dis_h) begin
                    w_addr_nxt  = w_rc;
                    w_cnt_nxt   = STALL_LOAD;
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_addr_nxt  = 4'h0;
                end
            end
            ST_FLUSH: begin
                // A nested CS-parity trap retargets the vector but keeps timing.
                if (w_nest_par) begin
                    w_addr_nxt = 4'h7;
                end else begin
                    w_addr_nxt = r_addr;
                end
                if (r_cnt == 4'h0) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'h1;
                end
            end
            ST_ISSUE: begin
                if (w_nest_par) begin
                    w_addr_nxt = 4'h7;
                end else begin
                    w_addr_nxt = r_addr;
                end
                if (trap_ack_h) begin
                    if (MASK_EN) begin
                        w_cnt_nxt   = MASK_LOAD;
                        w_state_nxt = ST_MASK;
                    end else begin
                        w_addr_nxt  = 4'h0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_MASK: begin
                if (r_cnt == 4'h0) begin
                    w_addr_nxt  = 4'h0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'h1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'h0;
                w_addr_nxt  = 4'h0;
            end
        endcase
    end

    // Sticky nested-trap flag (set beats clear) and probe-vector capture.
    always_comb begin
        if (w_nest) begin
            w_dbl_nxt = 1'b1;
        end else if (clr_dbl_h) begin
            w_dbl_nxt = 1'b0;
        end else begin
            w_dbl_nxt = r_dbl;
        end
        if ((r_state == ST_IDLE) && m_clk_en_h && pte_check_or_probe_h) begin
            w_uvec_nxt = micro_vector_h;
        end else begin
            w_uvec_nxt = r_uvec;
        end
    end

    // FSM state, counter and datapath registers.
    always_ff @(posedge b_clk_l or negedge init_l) begin
        if (!init_l) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'h0;
            r_addr  <= 4'h0;
            r_dbl   <= 1'b0;
            r_uvec  <= 2'b11;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_dbl   <= w_dbl_nxt;
            r_uvec  <= w_uvec_nxt;
        end
    end

    // Status outputs registered from the next state so they track the state register exactly.
    always_ff @(posedge b_clk_l or negedge init_l) begin
        if (!init_l) begin
            r_utrap_l <= 1'b1;
            r_stall   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_utrap_l <= (w_state_nxt != ST_ISSUE);
            r_stall   <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_ISSUE);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign utrap_l       = r_utrap_l;
    assign trap_addr_h   = r_addr;
    assign clk_stall_h   = r_stall;
    assign trap_busy_h   = r_busy;
    assign double_trap_h = r_dbl;
    assign uvec_h        = r_uvec;

endmodule

// File: tb/tb_utrap_seq.sv
// Testbench for utrap_seq: two instances (default mask window and a 3-clock
// mask window) share one stimulus stream. A timestamp-based reference model
// predicts the outputs after every edge; a monitor compares them at negedge.
module tb_utrap_seq;

    localparam int STALL = 2;
    localparam int MASK0 = 1;
    localparam int MASK1 = 3;

    typedef struct packed {
        logic       utrap_l;
        logic [3:0] addr;
        logic       stall;
        logic       busy;
        logic       dbl;
        logic [1:0] uvec;
    } obs_t;

    typedef struct {
        int   at_edge;
        int   inst;
        obs_t exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       init_l;
    logic       en;
    logic [2:0] enc;
    logic       acv;
    logic       acv_en;
    logic       pte;
    logic [1:0] mv;
    logic       dis;
    logic       ack;
    logic       clr;

    logic [1:0] o_utrap_l;
    logic [3:0] o_addr [2];
    logic [1:0] o_stall;
    logic [1:0] o_busy;
    logic [1:0] o_dbl;
    logic [1:0] o_uvec [2];

    int  edge_cnt = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    sb_t q[$];

    // Reference model: a trap is described by its accept edge and ack edge.
    bit         m_active [2];
    bit         m_acked  [2];
    int         m_acc    [2];
    int         m_ackedge[2];
    logic [3:0] m_addr   [2];
    bit         m_dbl    [2];
    logic [1:0] m_uvec   [2];

    utrap_seq u_dut0 (
        .b_clk_l(clk), .init_l(init_l), .m_clk_en_h(en), .enc_utrap_l(enc),
        .acv_h(acv), .acv_chk_en_h(acv_en), .pte_check_or_probe_h(pte),
        .micro_vector_h(mv), .trap_dis_h(dis), .trap_ack_h(ack), .clr_dbl_h(clr),
        .utrap_l(o_utrap_l[0]), .trap_addr_h(o_addr[0]), .clk_stall_h(o_stall[0]),
        .trap_busy_h(o_busy[0]), .double_trap_h(o_dbl[0]), .uvec_h(o_uvec[0])
    );

    utrap_seq #(.STALL_CYC(STALL), .MASK_CYC(MASK1)) u_dut1 (
        .b_clk_l(clk), .init_l(init_l), .m_clk_en_h(en), .enc_utrap_l(enc),
        .acv_h(acv), .acv_chk_en_h(acv_en), .pte_check_or_probe_h(pte),
        .micro_vector_h(mv), .trap_dis_h(dis), .trap_ack_h(ack), .clr_dbl_h(clr),
        .utrap_l(o_utrap_l[1]), .trap_addr_h(o_addr[1]), .clk_stall_h(o_stall[1]),
        .trap_busy_h(o_busy[1]), .double_trap_h(o_dbl[1]), .uvec_h(o_uvec[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to match scoreboard entries to the edge they describe.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int mask_of(input int i);
        return (i == 0) ? MASK0 : MASK1;
    endfunction

    function automatic obs_t actual(input int i);
        obs_t o;
        o.utrap_l = o_utrap_l[i];
        o.addr    = o_addr[i];
        o.stall   = o_stall[i];
        o.busy    = o_busy[i];
        o.dbl     = o_dbl[i];
        o.uvec    = o_uvec[i];
        return o;
    endfunction

    // Phase seen just before edge n: 0 idle, 1 flush, 2 issue, 3 mask.
    function automatic int phase(input int i, input int n);
        if (!m_active[i]) return 0;
        if (m_acked[i]) return (n <= m_ackedge[i] + mask_of(i)) ? 3 : 0;
        if (n <= m_acc[i] + STALL) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_acked[i]  = 1'b0;
            m_addr[i]   = 4'h0;
            m_dbl[i]    = 1'b0;
            m_uvec[i]   = 2'b11;
        end
    endtask

    task automatic model_edge(input int i, input int n);
        int         ph;
        logic [2:0] code;
        bit         acv_t;
        bit         treq;
        bit         nest;
        ph    = phase(i, n);
        code  = ~enc;
        acv_t = acv && acv_en && !pte;
        treq  = (code != 3'd0) || acv_t;
        nest  = 1'b0;
        if (ph == 0) begin
            if (en && pte) m_uvec[i] = mv;
            if (en && treq && !dis) begin
                m_active[i] = 1'b1;
                m_acked[i]  = 1'b0;
                m_acc[i]    = n;
                m_addr[i]   = (code != 3'd0) ? {1'b0, code} : 4'h8;
            end
        end else if (ph == 1 || ph == 2) begin
            if (en && treq) begin
                nest = 1'b1;
                if (code == 3'd7) m_addr[i] = 4'h7;
            end
            if (ph == 2 && ack) begin
                m_acked[i]   = 1'b1;
                m_ackedge[i] = n;
            end
        end
        if (nest) m_dbl[i] = 1'b1;
        else if (clr) m_dbl[i] = 1'b0;
        if (m_active[i] && m_acked[i] && n >= m_ackedge[i] + mask_of(i)) begin
            m_active[i] = 1'b0;
            m_addr[i]   = 4'h0;
        end
    endtask

    // One clock: predict both instances for the coming edge, then advance to the next negedge.
    task automatic step();
        int   n;
        int   ph;
        sb_t  e;
        n = edge_cnt + 1;
        for (int i = 0; i < 2; i++) begin
            model_edge(i, n);
            ph            = phase(i, n + 1);
            e.at_edge     = n;
            e.inst        = i;
            e.exp.utrap_l = (ph != 2);
            e.exp.addr    = m_addr[i];
            e.exp.stall   = (ph == 1 || ph == 2);
            e.exp.busy    = (ph != 0);
            e.exp.dbl     = m_dbl[i];
            e.exp.uvec    = m_uvec[i];
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_idle();
        en = 1'b1; enc = 3'b111; acv = 1'b0; acv_en = 1'b0; pte = 1'b0;
        mv = 2'b00; dis = 1'b0; ack = 1'b0; clr = 1'b0;
    endtask

    // Monitor: compare every scoreboard entry belonging to the edge just taken.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at_edge == edge_cnt) begin
            sb_t  e;
            obs_t a;
            e = q.pop_front();
            a = actual(e.inst);
            n_checks++;
            if (a === e.exp) n_pass++;
            else $display("FAIL edge%0d dut%0d {utrap_l,addr,stall,busy,dbl,uvec}: got %b expected %b",
                          e.at_edge, e.inst, a, e.exp);
        end
    end

    // Directed scenarios, randomized traffic and an asynchronous reset in ISSUE.
    initial begin
        init_l = 1'b0;
        set_idle();
        model_reset();
        #12;
        check("reset_dut0", 32'(actual(0)), 32'(10'b1_0000_0_0_0_11));
        check("reset_dut1", 32'(actual(1)), 32'(10'b1_0000_0_0_0_11));
        @(negedge clk);
        init_l = 1'b1;
        step();

        // Basic trap, code 1, ack at edge 5.
        enc = 3'b110; step();               // edge 0
        enc = 3'b111; step(); step();       // edges 1, 2
        check("basic_utrap_low", 32'(o_utrap_l[0]), 32'd0);
        check("basic_addr", 32'(o_addr[0]), 32'd1);
        step(); step();                     // edges 3, 4
        ack = 1'b1; step();                 // edge 5
        ack = 1'b0;
        check("basic_utrap_after_ack", 32'(o_utrap_l[0]), 32'd1);
        check("basic_stall_after_ack", 32'(o_stall[0]), 32'd0);
        step();                             // edge 6
        check("basic_idle", 32'(o_busy[0]), 32'd0);
        check("basic_addr_zero", 32'(o_addr[0]), 32'd0);
        repeat (4) step();

        // ACV trap.
        acv = 1'b1; acv_en = 1'b1; step();
        set_idle(); step(); step();
        check("acv_addr", 32'(o_addr[0]), 32'd8);
        ack = 1'b1; step(); ack = 1'b0;
        repeat (4) step();

        // ACV gated by probe; probe vector captured.
        acv = 1'b1; acv_en = 1'b1; pte = 1'b1; mv = 2'b01; step();
        check("acv_probe_gated", 32'(o_busy[0]), 32'd0);
        check("uvec_capture", 32'(o_uvec[0]), 32'd1);
        en = 1'b0; acv = 1'b0; mv = 2'b10; step();
        check("uvec_hold", 32'(o_uvec[0]), 32'd1);
        set_idle(); acv = 1'b1; acv_en = 1'b1; dis = 1'b1; step();
        check("acv_trap_dis", 32'(o_busy[0]), 32'd0);
        set_idle(); step();

        // Parity override during FLUSH.
        enc = 3'b101; step();
        enc = 3'b000; step();
        enc = 3'b111; step();
        check("par_addr", 32'(o_addr[0]), 32'd7);
        check("par_dbl", 32'(o_dbl[0]), 32'd1);
        check("par_issue_timing", 32'(o_utrap_l[0]), 32'd0);
        ack = 1'b1; step();
        ack = 1'b0; clr = 1'b1; step();
        clr = 1'b0;
        check("par_dbl_clear", 32'(o_dbl[0]), 32'd0);
        repeat (4) step();

        // Mask window: code 4 held through the ack.
        enc = 3'b011; step(); step(); step();   // accept E, ISSUE after E+2
        ack = 1'b1; step(); ack = 1'b0;          // A = E+3
        step(); step(); step();                  // A+1..A+3
        check("mask3_not_yet", 32'(o_busy[1]), 32'd0);
        step();                                  // A+4
        check("mask3_reaccept", 32'(o_busy[1]), 32'd1);
        set_idle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            en     = ($urandom_range(0, 9) < 7);
            enc    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            acv    = ($urandom_range(0, 3) == 0);
            acv_en = 1'($urandom_range(0, 1));
            pte    = ($urandom_range(0, 3) == 0);
            mv     = 2'($urandom_range(0, 3));
            dis    = ($urandom_range(0, 4) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            clr    = ($urandom_range(0, 7) == 0);
            step();
        end

        // Drain, then take a trap to ISSUE and reset asynchronously.
        set_idle(); en = 1'b0; ack = 1'b1;
        repeat (12) step();
        set_idle();
        enc = 3'b110; step();
        enc = 3'b111; step(); step();
        #2;
        init_l = 1'b0;
        #1;
        model_reset();
        check("rst_utrap_l", 32'(o_utrap_l[0]), 32'd1);
        check("rst_stall", 32'(o_stall[0]), 32'd0);
        check("rst_uvec", 32'(o_uvec[0]), 32'd3);
        check("rst_addr", 32'(o_addr[0]), 32'd0);
        check("rst_dut1", 32'(actual(1)), 32'(10'b1_0000_0_0_0_11));
        @(negedge clk);
        init_l = 1'b1;
        repeat (4) step();
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
